// File: rtl/fir_systolic.sv
// Transposed-form systolic FIR with a double-buffered coefficient bank, rounding and flush.
// Define FIR_SATURATE_EN to clamp the narrowed output; otherwise it wraps and o_sat stays 0.
module fir_systolic #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 18,
  parameter int NUM_TAPS   = 8,
  parameter int OUT_SHIFT  = 17
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  input  logic                        i_valid,
  input  logic [DATA_WIDTH-1:0]       iv_din,
  input  logic                        i_coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] iv_coef_addr,
  input  logic [COEF_WIDTH-1:0]       iv_coef_data,
  input  logic                        i_coef_commit,
  output logic                        o_valid,
  output logic [DATA_WIDTH-1:0]       ov_dout,
  output logic                        o_sat
);

  localparam int PROD_W    = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_WIDTH = PROD_W + $clog2(NUM_TAPS);
  localparam int RND_W     = ACC_WIDTH + 1;

  localparam logic signed [RND_W-1:0] RND_CONST =
    (OUT_SHIFT > 0) ? (RND_W'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [RND_W-1:0] SAT_MAX =
    {{(RND_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN =
    {{(RND_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [COEF_WIDTH-1:0] shadow_bank [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] active_bank [NUM_TAPS];
  logic                         coef_addr_ok;

  logic                         s1_valid;
  logic signed [DATA_WIDTH-1:0] s1_din;
  logic                         s2_valid;
  logic signed [PROD_W-1:0]     prod [NUM_TAPS];
  logic                         s3_valid;
  logic signed [ACC_WIDTH-1:0]  psum [1:NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]  acc;

  logic signed [RND_W-1:0]      acc_rnd;
  logic signed [RND_W-1:0]      shifted;
  logic [DATA_WIDTH-1:0]        dout_next;
  logic                         sat_next;

  assign coef_addr_ok = (32'(iv_coef_addr) < NUM_TAPS);

  // Commit reads the shadow bank before this edge's write lands in it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_bank[k] <= '0;
        active_bank[k] <= '0;
      end
    end else begin
      if (i_coef_commit) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          active_bank[k] <= shadow_bank[k];
        end
      end
      if (i_coef_we && coef_addr_ok) begin
        shadow_bank[iv_coef_addr] <= iv_coef_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_din   <= '0;
    end else begin
      s1_valid <= i_valid & ~i_clear;
      if (i_valid) begin
        s1_din <= iv_din;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod[k] <= '0;
      end
    end else begin
      s2_valid <= s1_valid & ~i_clear;
      if (s1_valid) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          prod[k] <= PROD_W'(active_bank[k]) * PROD_W'(s1_din);
        end
      end
    end
  end

  // psum[NUM_TAPS] is never loaded, so it terminates the chain with zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s3_valid <= 1'b0;
      acc      <= '0;
      for (int k = 1; k <= NUM_TAPS; k++) begin
        psum[k] <= '0;
      end
    end else if (i_clear) begin
      s3_valid <= 1'b0;
      for (int k = 1; k <= NUM_TAPS; k++) begin
        psum[k] <= '0;
      end
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        for (int k = 1; k < NUM_TAPS; k++) begin
          psum[k] <= ACC_WIDTH'(prod[k]) + psum[k+1];
        end
        acc <= ACC_WIDTH'(prod[0]) + psum[1];
      end
    end
  end

  always_comb begin
    acc_rnd   = RND_W'(acc) + RND_CONST;
    shifted   = acc_rnd >>> OUT_SHIFT;
    dout_next = shifted[DATA_WIDTH-1:0];
    sat_next  = 1'b0;
`ifdef FIR_SATURATE_EN
    if (shifted > SAT_MAX) begin
      dout_next = SAT_MAX[DATA_WIDTH-1:0];
      sat_next  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      dout_next = SAT_MIN[DATA_WIDTH-1:0];
      sat_next  = 1'b1;
    end
`endif
  end

`ifndef FIR_SATURATE_EN
  logic unused_high;
  assign unused_high = ^{shifted[RND_W-1:DATA_WIDTH], SAT_MAX, SAT_MIN};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
      ov_dout <= '0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= s3_valid;
      o_sat   <= s3_valid & sat_next;
      if (s3_valid) begin
        ov_dout <= dout_next;
      end
    end
  end

endmodule
